busca_operandos: RTL and testbench

BUSCA_OPERANDOS -- requirements
Module: busca_operandos

---
 rtl/busca_operandos.sv | 94 +++++++++
 tb/tb_busca_operandos.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/busca_operandos.sv
// Operand-fetch stage: 32x32 register file with write-back bypass, immediate
// extension, and a one-deep output register that holds under ALU back-pressure.
module busca_operandos (
  input  logic        clock,
  input  logic        reset,
  input  logic        entValida,
  output logic        entPronta,
  input  logic [4:0]  regFonte1,
  input  logic [4:0]  regFonte2,
  input  logic [15:0] imediato,
  input  logic        usaImediato,
  input  logic [3:0]  ulaControleEnt,
  input  logic        escreveReg,
  input  logic [4:0]  regDestino,
  input  logic [31:0] dadoEscrita,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  ulaControle,
  output logic        saidaValida,
  input  logic        ulaPronta
);

  // Handshake: an instruction moves on every edge where entValida && entPronta.
  // Once saidaValida is high, A/B/ulaControle stay stable until ulaPronta is seen.
  typedef enum logic {VAZIO = 1'b0, CHEIO = 1'b1} estado_t;

  estado_t     estado_q, estado_d;
  logic [31:0] regs_q [32];
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] rd1, rd2, imm_ext;
  logic        aceita;

  assign saidaValida = (estado_q == CHEIO);
  assign entPronta   = !saidaValida || ulaPronta;
  assign aceita      = entValida && entPronta;
  assign A           = a_q;
  assign B           = b_q;
  assign ulaControle = op_q;

  always_comb begin
    rd1 = regs_q[regFonte1];
    rd2 = regs_q[regFonte2];
    if (escreveReg && (regDestino == regFonte1)) rd1 = dadoEscrita;
    if (escreveReg && (regDestino == regFonte2)) rd2 = dadoEscrita;
    if (regFonte1 == 5'd0) rd1 = 32'd0;
    if (regFonte2 == 5'd0) rd2 = 32'd0;
    // andi/ori treat the immediate as unsigned; everything else sign-extends.
    if ((ulaControleEnt == 4'd2) || (ulaControleEnt == 4'd3))
      imm_ext = {16'd0, imediato};
    else
      imm_ext = {{16{imediato[15]}}, imediato};
  end

  always_comb begin
    estado_d = estado_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    if (aceita) begin
      a_d  = rd1;
      b_d  = usaImediato ? imm_ext : rd2;
      op_d = ulaControleEnt;
    end
    case (estado_q)
      VAZIO:   if (aceita) estado_d = CHEIO;
      CHEIO:   if (ulaPronta && !entValida) estado_d = VAZIO;
      default: estado_d = VAZIO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= VAZIO;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      op_q     <= 4'd0;
    end else begin
      estado_q <= estado_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
    end else if (escreveReg && (regDestino != 5'd0)) begin
      regs_q[regDestino] <= dadoEscrita;
    end
  end

endmodule

// File: tb/tb_busca_operandos.sv
// Directed bench for busca_operandos: bypass, immediates, stall, r0 and async reset.
module tb_busca_operandos;

  logic        clock = 1'b0;
  logic        reset;
  logic        entValida;
  logic        entPronta;
  logic [4:0]  regFonte1, regFonte2;
  logic [15:0] imediato;
  logic        usaImediato;
  logic [3:0]  ulaControleEnt;
  logic        escreveReg;
  logic [4:0]  regDestino;
  logic [31:0] dadoEscrita;
  logic [31:0] A, B;
  logic [3:0]  ulaControle;
  logic        saidaValida;
  logic        ulaPronta;

  int n_checks = 0;
  int n_fails  = 0;

  busca_operandos dut (
    .clock(clock), .reset(reset), .entValida(entValida), .entPronta(entPronta),
    .regFonte1(regFonte1), .regFonte2(regFonte2), .imediato(imediato),
    .usaImediato(usaImediato), .ulaControleEnt(ulaControleEnt),
    .escreveReg(escreveReg), .regDestino(regDestino), .dadoEscrita(dadoEscrita),
    .A(A), .B(B), .ulaControle(ulaControle), .saidaValida(saidaValida),
    .ulaPronta(ulaPronta)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic imm_sel, input logic [15:0] imm, input logic [3:0] op);
    entValida      = 1'b1;
    regFonte1      = rs1;
    regFonte2      = rs2;
    usaImediato    = imm_sel;
    imediato       = imm;
    ulaControleEnt = op;
  endtask

  task automatic check_out(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                           input logic [3:0] eop, input logic ev);
    chk({tag, ".A"}, A, ea);
    chk({tag, ".B"}, B, eb);
    chk({tag, ".op"}, {28'd0, ulaControle}, {28'd0, eop});
    chk({tag, ".valid"}, {31'd0, saidaValida}, {31'd0, ev});
  endtask

  initial begin
    reset = 1'b1; entValida = 1'b0; regFonte1 = '0; regFonte2 = '0;
    imediato = '0; usaImediato = 1'b0; ulaControleEnt = '0;
    escreveReg = 1'b0; regDestino = '0; dadoEscrita = '0; ulaPronta = 1'b1;

    // Reset state before any clock edge
    #2;
    check_out("reset_init", 32'd0, 32'd0, 4'd0, 1'b0);
    chk("reset_init.pronta", {31'd0, entPronta}, 32'd1);

    // Activity during reset is ignored: no acceptance, no write to r3
    issue(5'd0, 5'd0, 1'b0, 16'd0, 4'd1);
    escreveReg = 1'b1; regDestino = 5'd3; dadoEscrita = 32'h33;
    step();
    check_out("reset_busy", 32'd0, 32'd0, 4'd0, 1'b0);
    chk("reset_busy.pronta", {31'd0, entPronta}, 32'd1);

    // First edge after reset accepts
    reset = 1'b0; escreveReg = 1'b0;
    issue(5'd0, 5'd0, 1'b0, 16'd0, 4'd1);
    step();
    check_out("first_edge", 32'd0, 32'd0, 4'd1, 1'b1);

    // Drain to VAZIO while writing r5; outputs keep last values
    entValida = 1'b0; escreveReg = 1'b1; regDestino = 5'd5; dadoEscrita = 32'h0000_00AA;
    step();
    check_out("drain", 32'd0, 32'd0, 4'd1, 1'b0);
    chk("drain.pronta", {31'd0, entPronta}, 32'd1);

    // Read back r5 from the file
    escreveReg = 1'b0;
    issue(5'd5, 5'd0, 1'b0, 16'd0, 4'd0);
    step();
    check_out("wb_r5", 32'h0000_00AA, 32'd0, 4'd0, 1'b1);

    // Same-cycle write-back of r7 and acceptance reading r7
    escreveReg = 1'b1; regDestino = 5'd7; dadoEscrita = 32'h1234;
    issue(5'd7, 5'd5, 1'b0, 16'd0, 4'd4);
    step();
    check_out("bypass_r7", 32'h1234, 32'h0000_00AA, 4'd4, 1'b1);
    escreveReg = 1'b0;
    issue(5'd7, 5'd0, 1'b0, 16'd0, 4'd5);
    step();
    check_out("file_r7", 32'h1234, 32'd0, 4'd5, 1'b1);

    // Immediate extension
    issue(5'd5, 5'd0, 1'b1, 16'hFFF0, 4'd0);
    step();
    check_out("imm_sext", 32'h0000_00AA, 32'hFFFF_FFF0, 4'd0, 1'b1);
    issue(5'd5, 5'd0, 1'b1, 16'hFFF0, 4'd3);
    step();
    check_out("imm_ori", 32'h0000_00AA, 32'h0000_FFF0, 4'd3, 1'b1);
    issue(5'd0, 5'd0, 1'b1, 16'h8001, 4'd2);
    step();
    check_out("imm_andi", 32'd0, 32'h0000_8001, 4'd2, 1'b1);
    issue(5'd0, 5'd0, 1'b1, 16'h7FFF, 4'd1);
    step();
    check_out("imm_pos", 32'd0, 32'h0000_7FFF, 4'd1, 1'b1);
    issue(5'd0, 5'd0, 1'b1, 16'h8000, 4'd15);
    step();
    check_out("op15", 32'd0, 32'hFFFF_8000, 4'd15, 1'b1);

    // Stall: hold for 3 cycles despite a pending op and a write to r5
    issue(5'd5, 5'd7, 1'b0, 16'd0, 4'd6);
    step();
    check_out("stall_load", 32'h0000_00AA, 32'h1234, 4'd6, 1'b1);
    ulaPronta = 1'b0;
    issue(5'd5, 5'd7, 1'b0, 16'd0, 4'd8);
    escreveReg = 1'b1; regDestino = 5'd5; dadoEscrita = 32'h55;
    #1;
    chk("stall.pronta0", {31'd0, entPronta}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      escreveReg = 1'b0;
      #1;
      chk($sformatf("stall%0d.pronta", i), {31'd0, entPronta}, 32'd0);
      check_out($sformatf("stall%0d", i), 32'h0000_00AA, 32'h1234, 4'd6, 1'b1);
    end
    ulaPronta = 1'b1;
    step();
    check_out("stall_release", 32'h55, 32'h1234, 4'd8, 1'b1);

    // Register 0 ignores writes and bypass; r3 stayed 0 through reset activity
    escreveReg = 1'b1; regDestino = 5'd0; dadoEscrita = 32'hDEAD;
    issue(5'd0, 5'd3, 1'b0, 16'd0, 4'd9);
    step();
    check_out("r0_bypass", 32'd0, 32'd0, 4'd9, 1'b1);
    escreveReg = 1'b0;
    issue(5'd0, 5'd0, 1'b0, 16'd0, 4'd10);
    step();
    check_out("r0_read", 32'd0, 32'd0, 4'd10, 1'b1);

    // Asynchronous reset while holding an operation
    issue(5'd5, 5'd7, 1'b0, 16'd0, 4'd7);
    step();
    check_out("pre_reset", 32'h55, 32'h1234, 4'd7, 1'b1);
    ulaPronta = 1'b0; entValida = 1'b0;
    step();
    check_out("pre_reset_hold", 32'h55, 32'h1234, 4'd7, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    check_out("async_reset", 32'd0, 32'd0, 4'd0, 1'b0);
    chk("async_reset.pronta", {31'd0, entPronta}, 32'd1);
    step();
    reset = 1'b0; ulaPronta = 1'b1;
    issue(5'd5, 5'd7, 1'b0, 16'd0, 4'd11);
    step();
    check_out("post_reset_regs", 32'd0, 32'd0, 4'd11, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
